// File: rtl/alu_share_ctrl_if.sv
// Bus interface for alu_share_ctrl.
// Carries the two client request channels, the shared result/handshake
// signals and the connection to the external combinational ALU.
// slave  : the controller side
// master : the client/ALU harness side
interface alu_share_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int OPRN_W = 6
);
   // client request channels
   logic              req0;
   logic              req1;
   logic [OPRN_W-1:0] oprn0;
   logic [OPRN_W-1:0] oprn1;
   logic [DATA_W-1:0] op1Cl0;
   logic [DATA_W-1:0] op2Cl0;
   logic [DATA_W-1:0] op1Cl1;
   logic [DATA_W-1:0] op2Cl1;

   // completion handshake and shared result
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] res;
   logic              zeroRes;
   logic              err;
   logic              busy;

   // connection to the shared ALU
   logic [DATA_W-1:0] aluOp1;
   logic [DATA_W-1:0] aluOp2;
   logic [OPRN_W-1:0] aluOprn;
   logic [DATA_W-1:0] aluOut;
   logic              aluZero;

   modport slave (
      input  req0, req1, oprn0, oprn1, op1Cl0, op2Cl0, op1Cl1, op2Cl1,
      input  aluOut, aluZero,
      output ack0, ack1, res, zeroRes, err, busy,
      output aluOp1, aluOp2, aluOprn
   );

   modport master (
      output req0, req1, oprn0, oprn1, op1Cl0, op2Cl0, op1Cl1, op2Cl1,
      output aluOut, aluZero,
      input  ack0, ack1, res, zeroRes, err, busy,
      input  aluOp1, aluOp2, aluOprn
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two clients share one combinational ALU.
// A request is granted in IDLE, its operands are registered into the ALU in
// EXEC, and the captured result is returned with a one-cycle ACK in DONE.
// Optional build macro ALU_SHARE_FIXED_PRI_EN: when defined, client 0 always
// wins a simultaneous request; otherwise the two clients alternate.
module alu_share_ctrl #(
   parameter int DATA_W   = 32,
   parameter int OPRN_W   = 6,
   parameter int OPRN_MAX = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_share_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              lastGnt_q, lastGnt_d;
   logic              illegal_q, illegal_d;
   logic [DATA_W-1:0] aluOp1_q, aluOp1_d;
   logic [DATA_W-1:0] aluOp2_q, aluOp2_d;
   logic [OPRN_W-1:0] aluOprn_q, aluOprn_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              zeroRes_q, zeroRes_d;
   logic              err_q, err_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;

   logic              anyReq;
   logic              pick;
   logic [OPRN_W-1:0] selOprn;
   logic [DATA_W-1:0] selOp1;
   logic [DATA_W-1:0] selOp2;
   logic              selIllegal;

   assign anyReq = bus.req0 | bus.req1;

   // Arbitration: pick the client to serve if a grant happens this cycle
   always_comb begin
      pick = 1'b0;
      if (bus.req0 && bus.req1) begin
`ifdef ALU_SHARE_FIXED_PRI_EN
         pick = 1'b0;
`else
         pick = ~lastGnt_q;
`endif
      end else if (bus.req1) begin
         pick = 1'b1;
      end
   end

   // Operand mux for the picked client, plus the illegal-opcode check
   always_comb begin
      selOprn    = pick ? bus.oprn1  : bus.oprn0;
      selOp1     = pick ? bus.op1Cl1 : bus.op1Cl0;
      selOp2     = pick ? bus.op2Cl1 : bus.op2Cl0;
      selIllegal = (selOprn == '0) || (selOprn > OPRN_W'(OPRN_MAX));
   end

   // Next-state and next-output logic of the IDLE/EXEC/DONE sequence
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      lastGnt_d = lastGnt_q;
      illegal_d = illegal_q;
      aluOp1_d  = aluOp1_q;
      aluOp2_d  = aluOp2_q;
      aluOprn_d = aluOprn_q;
      res_d     = res_q;
      zeroRes_d = zeroRes_q;
      err_d     = err_q;
      ack0_d    = ack0_q;
      ack1_d    = ack1_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               gnt_d     = pick;
               lastGnt_d = pick;
               illegal_d = selIllegal;
               aluOp1_d  = selOp1;
               aluOp2_d  = selOp2;
               aluOprn_d = selOprn;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (illegal_q) begin
               res_d     = '0;
               zeroRes_d = 1'b1;
               err_d     = 1'b1;
            end else begin
               res_d     = bus.aluOut;
               zeroRes_d = bus.aluZero;
               err_d     = 1'b0;
            end
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            state_d = DONE;
         end
         DONE: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         lastGnt_q <= 1'b1;
         illegal_q <= 1'b0;
         aluOp1_q  <= '0;
         aluOp2_q  <= '0;
         aluOprn_q <= '0;
         res_q     <= '0;
         zeroRes_q <= 1'b0;
         err_q     <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         lastGnt_q <= lastGnt_d;
         illegal_q <= illegal_d;
         aluOp1_q  <= aluOp1_d;
         aluOp2_q  <= aluOp2_d;
         aluOprn_q <= aluOprn_d;
         res_q     <= res_d;
         zeroRes_q <= zeroRes_d;
         err_q     <= err_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
      end
   end

   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.res     = res_q;
   assign bus.zeroRes = zeroRes_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q == EXEC) || (state_q == DONE);
   assign bus.aluOp1  = aluOp1_q;
   assign bus.aluOp2  = aluOp2_q;
   assign bus.aluOprn = aluOprn_q;

endmodule
